// File: rtl/dest_write_sched.sv
// -----------------------------------------------------------------------------
// dest_write_sched
// Write-port scheduler for the 3-entry destination register set (S0..S2).
// Three requesters (0 = ALU result, 1 = memory load, 2 = immediate) compete
// for the single register-file write path. A winner is granted for one cycle,
// its destination select and data are latched, and WE is held for
// HOLD_CYCLES cycles. At least one IDLE cycle separates consecutive grants.
//
// Configuration macro:
//   DEST_SCHED_FIXED_PRI_EN  defined   -> fixed priority (0 highest, 2 lowest)
//                            undefined -> round-robin via pointer P (default)
//
// Parameters:
//   DW           write data width
//   HOLD_CYCLES  cycles WE stays high per write (1..8)
//
// Ports:
//   CLK1      in   clock, rising edge
//   RST_N     in   asynchronous active-low reset
//   REQ       in   per-requester write request, held until its GNT
//   REQ_DEST  in   2-bit destination per requester (3 = invalid)
//   REQ_DATA  in   DW-bit data per requester
//   ERR_CLR   in   synchronous clear of ERR (a simultaneous set wins)
//   GNT       out  one-hot single-cycle grant pulse
//   SEL       out  one-hot destination select (S0..S2)
//   WDATA     out  latched write data
//   WE        out  register-file write strobe
//   BUSY      out  high while a write is in progress
//   ERR       out  sticky invalid-destination flag
// -----------------------------------------------------------------------------
module dest_write_sched #(
    parameter int DW          = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic              CLK1,
    input  logic              RST_N,
    input  logic [2:0]        REQ,
    input  logic [5:0]        REQ_DEST,
    input  logic [3*DW-1:0]   REQ_DATA,
    input  logic              ERR_CLR,
    output logic [2:0]        GNT,
    output logic [2:0]        SEL,
    output logic [DW-1:0]     WDATA,
    output logic              WE,
    output logic              BUSY,
    output logic              ERR
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    // Counter value loaded on a valid grant; the write ends when it reaches 0.
    localparam logic [2:0] HOLD_LOAD = 3'(HOLD_CYCLES - 1);

    state_t          state_r, state_s;
    logic [2:0]      cnt_r, cnt_s;
    logic [2:0]      gnt_r, gnt_s;
    logic [2:0]      sel_r, sel_s;
    logic [DW-1:0]   wdata_r, wdata_s;
    logic            we_r, we_s;
    logic            busy_r, busy_s;
    logic            err_r, err_s;
    logic [1:0]      start_s;
    logic [1:0]      win_s;
    logic [1:0]      dest_s;
    logic [DW-1:0]   win_data_s;
`ifndef DEST_SCHED_FIXED_PRI_EN
    logic [1:0]      ptr_r, ptr_s;
`endif

    // (a + b) mod 3 for operands in 0..2
    function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 3'd3) begin
            return 2'(sum - 3'd3);
        end else begin
            return sum[1:0];
        end
    endfunction

    // First set request in the order start, start+1, start+2 (mod 3).
    // Scanning from the far end lets the nearest candidate overwrite the rest.
    function automatic logic [1:0] pick_winner(input logic [2:0] req, input logic [1:0] start);
        logic [1:0] win;
        logic [1:0] idx;
        win = start;
        for (int k = 2; k >= 0; k--) begin
            idx = mod3_add(start, 2'(k));
            if (req[idx]) begin
                win = idx;
            end
        end
        return win;
    endfunction

    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        case (idx)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Winner selection and extraction of its destination and data
    always_comb begin
`ifdef DEST_SCHED_FIXED_PRI_EN
        start_s = 2'd0;
`else
        start_s = ptr_r;
`endif
        win_s = pick_winner(REQ, start_s);
        case (win_s)
            2'd0: begin
                dest_s     = REQ_DEST[1:0];
                win_data_s = REQ_DATA[DW-1:0];
            end
            2'd1: begin
                dest_s     = REQ_DEST[3:2];
                win_data_s = REQ_DATA[2*DW-1:DW];
            end
            default: begin
                dest_s     = REQ_DEST[5:4];
                win_data_s = REQ_DATA[3*DW-1:2*DW];
            end
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        gnt_s   = 3'b000;
        sel_s   = sel_r;
        we_s    = we_r;
        wdata_s = wdata_r;
        // A set in this cycle overrides the clear below.
        err_s   = err_r & ~ERR_CLR;
`ifndef DEST_SCHED_FIXED_PRI_EN
        ptr_s   = ptr_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (REQ != 3'b000) begin
                    state_s = ST_WRITE;
                    gnt_s   = onehot3(win_s);
                    wdata_s = win_data_s;
`ifndef DEST_SCHED_FIXED_PRI_EN
                    ptr_s   = (win_s == 2'd2) ? 2'd0 : (win_s + 2'd1);
`endif
                    if (dest_s == 2'd3) begin
                        sel_s = 3'b000;
                        we_s  = 1'b0;
                        err_s = 1'b1;
                        cnt_s = 3'd0;
                    end else begin
                        sel_s = onehot3(dest_s);
                        we_s  = 1'b1;
                        cnt_s = HOLD_LOAD;
                    end
                end else begin
                    sel_s = 3'b000;
                    we_s  = 1'b0;
                end
            end
            ST_WRITE: begin
                if (cnt_r == 3'd0) begin
                    state_s = ST_IDLE;
                    sel_s   = 3'b000;
                    we_s    = 1'b0;
                end else begin
                    cnt_s = cnt_r - 3'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                sel_s   = 3'b000;
                we_s    = 1'b0;
                cnt_s   = 3'd0;
            end
        endcase
        busy_s = (state_s == ST_WRITE);
    end

    // State and registered outputs
    always_ff @(posedge CLK1 or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
            gnt_r   <= 3'b000;
            sel_r   <= 3'b000;
            wdata_r <= '0;
            we_r    <= 1'b0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            gnt_r   <= gnt_s;
            sel_r   <= sel_s;
            wdata_r <= wdata_s;
            we_r    <= we_s;
            busy_r  <= busy_s;
            err_r   <= err_s;
        end
    end

`ifndef DEST_SCHED_FIXED_PRI_EN
    // Round-robin pointer
    always_ff @(posedge CLK1 or negedge RST_N) begin
        if (!RST_N) begin
            ptr_r <= 2'd0;
        end else begin
            ptr_r <= ptr_s;
        end
    end
`endif

    assign GNT   = gnt_r;
    assign SEL   = sel_r;
    assign WDATA = wdata_r;
    assign WE    = we_r;
    assign BUSY  = busy_r;
    assign ERR   = err_r;

endmodule
